pipe_stage_skid: RTL and testbench

PIPE_STAGE_SKID -- requirements
Module: pipe_stage_skid

---
 rtl/pipe_pkg.sv | 23 ++
 rtl/pipe_slot.sv | 55 +++++
 rtl/pipe_stage_skid.sv | 154 +++++++++++++++
 tb/tb_pipe_stage_skid.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// ============================================================================
// Module   : pipe_pkg
// Brief    : Shared types and constants for the skid-buffered pipeline stage.
// Revision : 1.0
// ============================================================================
`default_nettype none

package pipe_pkg;

  localparam int CTRL_W_DEFAULT = 16;

  // All-zero control word: no write enables, no jump/branch.
  localparam logic [CTRL_W_DEFAULT-1:0] CTRL_BUBBLE = '0;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/pipe_slot.sv
// ============================================================================
// Module   : pipe_slot
// Brief    : One {valid, ctrl, data} holding register with load and clear.
// Revision : 1.0
// ============================================================================
`default_nettype none

module pipe_slot
  import pipe_pkg::*;
#(
  parameter int DATA_W = 128,
  parameter int CTRL_W = CTRL_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic              clr_i,
  input  logic              clr_data_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [DATA_W-1:0] data_o
);

  logic              valid_q;
  logic [CTRL_W-1:0] ctrl_q;
  logic [DATA_W-1:0] data_q;

  // Clear wins over load so a squashed entry can never be captured.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      ctrl_q  <= CTRL_W'(CTRL_BUBBLE);
      data_q  <= '0;
    end else if (clr_i) begin
      valid_q <= 1'b0;
      ctrl_q  <= CTRL_W'(CTRL_BUBBLE);
      if (clr_data_i) begin
        data_q <= '0;
      end
    end else if (load_i) begin
      valid_q <= 1'b1;
      ctrl_q  <= ctrl_i;
      data_q  <= data_i;
    end
  end

  assign valid_o = valid_q;
  assign ctrl_o  = ctrl_q;
  assign data_o  = data_q;

endmodule

`default_nettype wire

// File: rtl/pipe_stage_skid.sv
// ============================================================================
// Module   : pipe_stage_skid
// Brief    : Two-entry (MAIN + SKID) pipeline register with registered in_ready
//            and flush. Define PIPE_FLUSH_ZERO_DATA_EN to also clear payload on flush.
// Revision : 1.0
// ============================================================================
`default_nettype none

module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int DATA_W = 128,
  parameter int CTRL_W = CTRL_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occ
);

  state_t state_q;
  state_t state_d;
  logic   in_ready_q;

  logic w_push;
  logic w_pop;
  logic w_main_load;
  logic w_main_from_skid;
  logic w_main_clr;
  logic w_skid_load;
  logic w_skid_clr;
  logic w_clr_data;

  logic              w_main_vld;
  logic              w_skid_vld;
  logic [CTRL_W-1:0] w_skid_ctrl;
  logic [DATA_W-1:0] w_skid_data;
  logic [CTRL_W-1:0] w_main_ctrl_in;
  logic [DATA_W-1:0] w_main_data_in;

`ifdef PIPE_FLUSH_ZERO_DATA_EN
  assign w_clr_data = flush;
`else
  assign w_clr_data = 1'b0;
`endif

  assign w_push = in_valid && in_ready_q;
  assign w_pop  = out_valid && out_ready;

  always_comb begin
    state_d          = state_q;
    w_main_load      = 1'b0;
    w_main_from_skid = 1'b0;
    w_main_clr       = 1'b0;
    w_skid_load      = 1'b0;
    w_skid_clr       = 1'b0;
    if (flush) begin
      state_d    = EMPTY;
      w_main_clr = 1'b1;
      w_skid_clr = 1'b1;
    end else begin
      case (state_q)
        EMPTY: begin
          if (w_push) begin
            state_d     = ONE;
            w_main_load = 1'b1;
          end
        end
        ONE: begin
          if (w_push && w_pop) begin
            w_main_load = 1'b1;
          end else if (w_push) begin
            state_d     = TWO;
            w_skid_load = 1'b1;
          end else if (w_pop) begin
            state_d    = EMPTY;
            w_main_clr = 1'b1;
          end
        end
        TWO: begin
          // in_ready is low here, so only a pop can happen.
          if (w_pop) begin
            state_d          = ONE;
            w_main_load      = 1'b1;
            w_main_from_skid = 1'b1;
            w_skid_clr       = 1'b1;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != TWO);
    end
  end

  assign w_main_ctrl_in = w_main_from_skid ? w_skid_ctrl : in_ctrl;
  assign w_main_data_in = w_main_from_skid ? w_skid_data : in_data;

  pipe_slot #(
    .DATA_W (DATA_W),
    .CTRL_W (CTRL_W)
  ) u_main (
    .clk        (clk),
    .rst        (rst),
    .load_i     (w_main_load),
    .clr_i      (w_main_clr),
    .clr_data_i (w_clr_data),
    .ctrl_i     (w_main_ctrl_in),
    .data_i     (w_main_data_in),
    .valid_o    (w_main_vld),
    .ctrl_o     (out_ctrl),
    .data_o     (out_data)
  );

  pipe_slot #(
    .DATA_W (DATA_W),
    .CTRL_W (CTRL_W)
  ) u_skid (
    .clk        (clk),
    .rst        (rst),
    .load_i     (w_skid_load),
    .clr_i      (w_skid_clr),
    .clr_data_i (w_clr_data),
    .ctrl_i     (in_ctrl),
    .data_i     (in_data),
    .valid_o    (w_skid_vld),
    .ctrl_o     (w_skid_ctrl),
    .data_o     (w_skid_data)
  );

  assign in_ready  = in_ready_q;
  assign out_valid = (state_q != EMPTY);
  // SKID is only ever valid alongside MAIN, so the two valid bits encode 0/1/2.
  assign occ       = {w_skid_vld, w_main_vld & ~w_skid_vld};

endmodule

`default_nettype wire

// File: tb/tb_pipe_stage_skid.sv
// ============================================================================
// Module   : tb_pipe_stage_skid
// Brief    : Directed + random scoreboard bench for pipe_stage_skid.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_pipe_stage_skid;

  localparam int DW = 128;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [CW-1:0] in_ctrl;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] out_ctrl;
  logic [DW-1:0] out_data;
  logic [1:0]    occ;

  typedef struct {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } item_t;

  item_t q[$];
  int    m_occ = 0;
  int    n_checks = 0;
  int    n_fail = 0;

  always #5 clk = ~clk;

  pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ctrl   (in_ctrl),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ctrl  (out_ctrl),
    .out_data  (out_data),
    .occ       (occ)
  );

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d,
                       input logic ordy, input logic fl);
    in_valid  = v;
    in_ctrl   = c;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    @(posedge clk);
    #2;
  endtask

  // Monitor / reference model: samples mid-cycle, compares, then advances the model.
  initial begin
    logic  p;
    logic  pp;
    item_t it;
    forever begin
      @(negedge clk);
      chk("occ", DW'(occ), DW'(m_occ));
      chk("in_ready", DW'(in_ready), DW'(m_occ != 2));
      chk("out_valid", DW'(out_valid), DW'(m_occ != 0));
      if (!out_valid) chk("bubble_ctrl", DW'(out_ctrl), '0);
      p  = in_valid && (m_occ != 2);
      pp = (m_occ != 0) && out_ready;
      if (pp && !rst) begin
        if (q.size() == 0) begin
          chk("sb_underflow", DW'(1), DW'(0));
        end else begin
          chk("sb_ctrl", DW'(out_ctrl), DW'(q[0].c));
          chk("sb_data", out_data, q[0].d);
        end
      end
      if (rst || flush) begin
        q.delete();
        m_occ = 0;
      end else begin
        if (pp && q.size() != 0) void'(q.pop_front());
        if (p) begin
          it.c = in_ctrl;
          it.d = in_data;
          q.push_back(it);
        end
        m_occ = m_occ + int'(p) - int'(pp);
      end
    end
  end

  initial begin
    logic [DW-1:0] exp_flush_data;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b1; in_ctrl = 16'h00FF; in_data = 128'hDEAD;
    out_ready = 1'b0;

    // Reset held two cycles while upstream offers data.
    drive(1'b1, 16'h00FF, 128'hDEAD, 1'b0, 1'b0);
    drive(1'b1, 16'h00FF, 128'hDEAD, 1'b0, 1'b0);
    rst = 1'b0;
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    chk("rst_out_valid", DW'(out_valid), '0);
    chk("rst_occ", DW'(occ), '0);
    chk("rst_out_ctrl", DW'(out_ctrl), '0);
    chk("rst_out_data", out_data, '0);
    chk("rst_in_ready", DW'(in_ready), DW'(1));

    // Streaming with out_ready high: one-cycle latency, full throughput.
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 16'h0003, DW'(i), 1'b1, 1'b0);
      chk("stream_data", out_data, DW'(i));
      chk("stream_occ", DW'(occ), DW'(1));
    end
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    chk("stream_drain_occ", DW'(occ), '0);

    // Backpressure: A, B fill the stage; C must wait.
    drive(1'b1, 16'h0011, 128'h11, 1'b0, 1'b0);
    drive(1'b1, 16'h0022, 128'h22, 1'b0, 1'b0);
    chk("bp_occ2", DW'(occ), DW'(2));
    chk("bp_in_ready", DW'(in_ready), '0);
    drive(1'b1, 16'h0033, 128'h33, 1'b0, 1'b0);
    chk("bp_hold_occ", DW'(occ), DW'(2));
    chk("bp_hold_data", out_data, 128'h11);
    drive(1'b1, 16'h0033, 128'h33, 1'b1, 1'b0);
    chk("bp_b_data", out_data, 128'h22);
    drive(1'b1, 16'h0033, 128'h33, 1'b1, 1'b0);
    chk("bp_c_data", out_data, 128'h33);
    chk("bp_c_ctrl", DW'(out_ctrl), DW'(16'h0033));
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    chk("bp_drain_occ", DW'(occ), '0);

    // Flush from TWO with an entry offered.
`ifdef PIPE_FLUSH_ZERO_DATA_EN
    exp_flush_data = '0;
`else
    exp_flush_data = 128'h55;
`endif
    drive(1'b1, 16'h00A5, 128'h55, 1'b0, 1'b0);
    drive(1'b1, 16'h00A5, 128'h66, 1'b0, 1'b0);
    drive(1'b1, 16'h00A5, 128'h44, 1'b0, 1'b1);
    chk("fl_occ", DW'(occ), '0);
    chk("fl_out_valid", DW'(out_valid), '0);
    chk("fl_out_ctrl", DW'(out_ctrl), '0);
    chk("fl_out_data", out_data, exp_flush_data);
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    chk("fl_idle_occ", DW'(occ), '0);

    // Flush beats a simultaneous push and pop in ONE.
`ifdef PIPE_FLUSH_ZERO_DATA_EN
    exp_flush_data = '0;
`else
    exp_flush_data = 128'h66;
`endif
    drive(1'b1, 16'h00A5, 128'h66, 1'b0, 1'b0);
    drive(1'b1, 16'h00A5, 128'h77, 1'b1, 1'b1);
    chk("fl1_occ", DW'(occ), '0);
    chk("fl1_out_data", out_data, exp_flush_data);
    drive(1'b0, '0, '0, 1'b1, 1'b0);

    // Simultaneous push and pop in ONE for 10 cycles.
    drive(1'b1, 16'h000C, 128'h100, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 16'h000C, DW'(32'h101 + i), 1'b1, 1'b0);
      chk("sim_occ", DW'(occ), DW'(1));
      chk("sim_data", out_data, DW'(32'h101 + i));
    end
    drive(1'b0, '0, '0, 1'b1, 1'b0);

    // Mid-operation reset also wins over flush.
    drive(1'b1, 16'h0007, 128'h200, 1'b0, 1'b0);
    drive(1'b1, 16'h0007, 128'h201, 1'b0, 1'b0);
    rst = 1'b1;
    drive(1'b1, 16'h0007, 128'h202, 1'b1, 1'b1);
    rst = 1'b0;
    chk("mid_rst_occ", DW'(occ), '0);
    chk("mid_rst_data", out_data, '0);
    chk("mid_rst_ctrl", DW'(out_ctrl), '0);

    // Random traffic with 5% flush.
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 1)), 16'($urandom) | 16'h1,
            {$urandom, $urandom, $urandom, $urandom},
            1'($urandom_range(0, 1)), ($urandom_range(0, 99) < 5));
    end
    for (int i = 0; i < 4; i++) drive(1'b0, '0, '0, 1'b1, 1'b0);
    chk("final_sb_empty", DW'(q.size()), '0);
    chk("final_occ", DW'(occ), '0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
